freelist: RTL and testbench
===========================

Name: freelist

Overview:
- Physical-register free list feeding the 2-wide rename stage.
- Holds free PREG indices in a circular FIFO and serves up to 2 allocations per cycle, answering the rename stage's instr0/instr1 freelist requests.
- Reclaims old_prd of up to 2 committing instructions per cycle.
- Recovers speculative allocations on pipeline flush by rolling the read pointer back to a commit-tracked pointer.

Parameters:
- NUM_PREG, 64, total physical registers; PREG index width = log2(NUM_PREG).
- NUM_LREG, 32, architectural registers; p0..p(NUM_LREG-1) are mapped at reset.
- FL_DEPTH, NUM_PREG-NUM_LREG, FIFO entries. Pointers are log2(FL_DEPTH)+1 bits, where the MSB is the wrap bit.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- instr0_freelist_req  in  1  rename slot0 needs a PREG this cycle
- instr0_freelist_resp  out  PREG  PREG for slot0
- instr1_freelist_req  in  1  rename slot1 needs a PREG this cycle
- instr1_freelist_resp  out  PREG  PREG for slot1
- freelist_can_alloc  out  1  at least 2 free entries; rename stalls when low
- freelist_count  out  log2(FL_DEPTH)+1  current free entries
- commit0_valid  in  1  ROB commit slot0 retires
- commit0_need_to_wb  in  1  slot0 had a destination
- commit0_old_prd  in  PREG  PREG to return
- commit1_valid  in  1  ROB commit slot1 retires
- commit1_need_to_wb  in  1  slot1 had a destination
- commit1_old_prd  in  PREG  PREG to return
- flush_valid  in  1  redirect; discard all uncommitted allocations

Behaviour:

Reset (async, reset_n low):
- entry[i] = NUM_LREG+i for i in 0..FL_DEPTH-1.
- head = 0, arch_head = 0, tail = FL_DEPTH with the wrap bit set, so the FIFO is full.
- freelist_count = FL_DEPTH, freelist_can_alloc = 1.
- Outputs take these values immediately; they are not clock-gated.

Allocation (combinational response, registered pointer):
- instr0_freelist_resp = entry[head].
- instr1_freelist_resp = instr0_freelist_req ? entry[head+1] : entry[head]. Slot1 takes the head when slot0 does not allocate.
- Pop count = req0+req1, applied only when freelist_can_alloc=1 and flush_valid=0. head advances by the pop count at the clock edge.
- When freelist_can_alloc=0, nothing pops regardless of req. Rename/dispatch must hold the instructions.

Free (commit):
- A slot pushes when commitN_valid & commitN_need_to_wb & (commitN_old_prd != 0); p0 is never recycled.
- Slot0 is written at tail and slot1 at tail+push0. tail advances by the push count.
- Every committing slot with commitN_valid & commitN_need_to_wb advances arch_head by 1, including slots whose old_prd is 0. Allocation order equals commit order.

Count and pointer wrap:
- freelist_count = tail - head, modular over the pointer width.
- freelist_can_alloc = (freelist_count >= 2).
- Pointers wrap naturally. Indexing uses the low bits; the wrap bit distinguishes full from empty.

Flush:
- When flush_valid=1, allocations that cycle are ignored.
- head_next = arch_head_next, which includes commits in the same cycle. Commits in the same cycle still push.
- The cycle after a flush, count = tail_next - arch_head_next.

Simultaneous events:
- Alloc and free in the same cycle: count_next = count - pops + pushes.
- A PREG freed in cycle N is allocatable from cycle N+1 only; there is no same-cycle bypass.

Overflow:
- A push that would exceed FL_DEPTH is illegal.
- Simulation assertion fires on count > FL_DEPTH and on head passing tail.

Reset mid-operation: all pointers and entries return to the reset state asynchronously. In-flight requests are dropped.

Test Plan:
- Reset release, both req=1 -> resp0=32, resp1=33; next cycle resp0=34, count=30.
- Only instr1_req=1 right after reset -> resp1=32, head+1, count=31; resp0 also shows 32 but is not popped.
- 30 paired allocs, then req0=req1=1 at count=2 -> p62/p63 popped, count=0, can_alloc=0. Further reqs pop nothing and head holds.
- At count=0, commit0 old_prd=5 and commit1 old_prd=7 -> next cycle count=2, resp0=5, resp1=7, can_alloc=1.
- After reset, allocate 4 (p32..p35) and commit 1 with old_prd=3, then flush_valid -> head=arch_head=1; next resp0=33, count=31+1=32.
- Same cycle commit0_valid=1, need_to_wb=1, old_prd=0 with req0=1 -> no push, arch_head+1, count decrements by 1 only.

Source files
------------

// File: rtl/freelist.sv
// Physical-register free list for a 2-wide rename stage: circular FIFO of free
// PREG indices with 2 pops/cycle, 2 commit pushes/cycle and flush rollback.
module freelist #(
  parameter int NUM_PREG = 64,
  parameter int NUM_LREG = 32,
  parameter int FL_DEPTH = NUM_PREG - NUM_LREG
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            instr0_freelist_req,
  output logic [$clog2(NUM_PREG)-1:0]     instr0_freelist_resp,
  input  logic                            instr1_freelist_req,
  output logic [$clog2(NUM_PREG)-1:0]     instr1_freelist_resp,
  output logic                            freelist_can_alloc,
  output logic [$clog2(FL_DEPTH):0]       freelist_count,
  input  logic                            commit0_valid,
  input  logic                            commit0_need_to_wb,
  input  logic [$clog2(NUM_PREG)-1:0]     commit0_old_prd,
  input  logic                            commit1_valid,
  input  logic                            commit1_need_to_wb,
  input  logic [$clog2(NUM_PREG)-1:0]     commit1_old_prd,
  input  logic                            flush_valid
);
  localparam int PW   = $clog2(NUM_PREG);
  localparam int AW   = $clog2(FL_DEPTH);
  localparam int PTRW = AW + 1;

  // Handshake: a slot's req is honoured (popped) only in a cycle where
  // freelist_can_alloc=1 and flush_valid=0; resp is valid combinationally
  // in the same cycle and the head moves at the following clock edge.

  logic [PW-1:0]   entry [FL_DEPTH];
  logic [PTRW-1:0] head, arch_head, tail;
  logic [PTRW-1:0] head_next, arch_head_next, tail_next;
  logic [PTRW-1:0] head_p1, tail_slot1;
  logic [PTRW-1:0] pop_cnt, push_cnt, commit_cnt;
  logic [PTRW-1:0] count_next;
  logic            pop0, pop1, push0, push1, commit0_adv, commit1_adv;

  assign freelist_count     = tail - head;
  assign freelist_can_alloc = (freelist_count >= PTRW'(2));

  assign head_p1              = head + PTRW'(1);
  assign instr0_freelist_resp = entry[head[AW-1:0]];
  assign instr1_freelist_resp = instr0_freelist_req ? entry[head_p1[AW-1:0]]
                                                    : entry[head[AW-1:0]];

  assign pop0 = instr0_freelist_req & freelist_can_alloc & ~flush_valid;
  assign pop1 = instr1_freelist_req & freelist_can_alloc & ~flush_valid;

  // p0 is the hardwired zero register and never goes back on the list.
  assign commit0_adv = commit0_valid & commit0_need_to_wb;
  assign commit1_adv = commit1_valid & commit1_need_to_wb;
  assign push0       = commit0_adv & (commit0_old_prd != '0);
  assign push1       = commit1_adv & (commit1_old_prd != '0);

  assign pop_cnt    = PTRW'(pop0) + PTRW'(pop1);
  assign push_cnt   = PTRW'(push0) + PTRW'(push1);
  assign commit_cnt = PTRW'(commit0_adv) + PTRW'(commit1_adv);
  assign tail_slot1 = tail + PTRW'(push0);

  assign arch_head_next = arch_head + commit_cnt;
  assign tail_next      = tail + push_cnt;
  assign head_next      = flush_valid ? arch_head_next : (head + pop_cnt);
  assign count_next     = tail_next - head_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= PTRW'(FL_DEPTH);
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry[i] <= PW'(NUM_LREG + i);
      end
    end else begin
      head      <= head_next;
      arch_head <= arch_head_next;
      tail      <= tail_next;
      if (push0) entry[tail[AW-1:0]]       <= commit0_old_prd;
      if (push1) entry[tail_slot1[AW-1:0]] <= commit1_old_prd;
    end
  end

  // Modular count exceeding the depth means an over-push or head overtaking tail.
  a_count_range: assert property (@(posedge clock) disable iff (!reset_n)
    freelist_count <= PTRW'(FL_DEPTH));
  a_next_range: assert property (@(posedge clock) disable iff (!reset_n)
    count_next <= PTRW'(FL_DEPTH));

endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: a vector table from reset plus hand-written
// sequences for exhaustion, refill, flush rollback and async reset.
module tb_freelist;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0, req1;
  logic [5:0] resp0, resp1;
  logic       can_alloc;
  logic [5:0] count;
  logic       c0v, c0w, c1v, c1w, flush;
  logic [5:0] c0o, c1o;

  int total = 0;
  int bad   = 0;

  freelist dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .instr0_freelist_req (req0),
    .instr0_freelist_resp(resp0),
    .instr1_freelist_req (req1),
    .instr1_freelist_resp(resp1),
    .freelist_can_alloc  (can_alloc),
    .freelist_count      (count),
    .commit0_valid       (c0v),
    .commit0_need_to_wb  (c0w),
    .commit0_old_prd     (c0o),
    .commit1_valid       (c1v),
    .commit1_need_to_wb  (c1w),
    .commit1_old_prd     (c1o),
    .flush_valid         (flush)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       r0, r1, c0v, c0w;
    logic [5:0] c0o;
    logic       c1v, c1w;
    logic [5:0] c1o;
    logic       fl;
    logic [5:0] e_r0, e_r1, e_cnt;
    logic       e_can;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(int r0, int r1, int v0, int w0, int o0,
                              int v1, int w1, int o1, int fl,
                              int er0, int er1, int ecnt, int ecan);
    vec_t v;
    v.r0 = r0[0]; v.r1 = r1[0]; v.c0v = v0[0]; v.c0w = w0[0]; v.c0o = 6'(o0);
    v.c1v = v1[0]; v.c1w = w1[0]; v.c1o = 6'(o1); v.fl = fl[0];
    v.e_r0 = 6'(er0); v.e_r1 = 6'(er1); v.e_cnt = 6'(ecnt); v.e_can = ecan[0];
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; c0v = 0; c0w = 0; c0o = '0;
    c1v = 0; c1w = 0; c1o = '0; flush = 0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset_n = 0;
    #1;
    chk("rst_count", count, 32);
    chk("rst_can", can_alloc, 1);
    chk("rst_resp0", resp0, 32);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic next_step();
    @(negedge clock);
    idle_inputs();
  endtask

  initial begin
    reset_n = 1;
    idle_inputs();
    // Table starts from reset: head=0, tail=32 (wrap set)
    vecs[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 32, 33, 32, 1);
    vecs[1] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 34, 34, 30, 1);
    vecs[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 35, 35, 29, 1);
    vecs[3] = mk(1, 0, 1, 1, 5, 0, 0, 0, 0, 35, 36, 29, 1);
    vecs[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 36, 36, 29, 1);
    vecs[5] = mk(1, 1, 0, 0, 0, 1, 1, 0, 1, 36, 37, 29, 1);
    vecs[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 34, 34, 31, 1);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      c0v = vecs[i].c0v; c0w = vecs[i].c0w; c0o = vecs[i].c0o;
      c1v = vecs[i].c1v; c1w = vecs[i].c1w; c1o = vecs[i].c1o;
      flush = vecs[i].fl;
      #1;
      chk($sformatf("vec%0d_resp0", i), resp0, vecs[i].e_r0);
      chk($sformatf("vec%0d_resp1", i), resp1, vecs[i].e_r1);
      chk($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
      chk($sformatf("vec%0d_can", i), can_alloc, vecs[i].e_can);
      next_step();
    end

    // Slot1 alone takes the head
    do_reset();
    req1 = 1; #1;
    chk("s1only_resp1", resp1, 32);
    chk("s1only_resp0", resp0, 32);
    next_step(); #1;
    chk("s1only_next_resp0", resp0, 33);
    chk("s1only_next_count", count, 31);
    next_step();

    // Exhaust, hold when empty, refill from commit
    do_reset();
    for (int i = 0; i < 15; i++) begin
      req0 = 1; req1 = 1; #1;
      chk("drain_count", count, 32 - 2 * i);
      next_step();
    end
    req0 = 1; req1 = 1; #1;
    chk("last_resp0", resp0, 62);
    chk("last_resp1", resp1, 63);
    chk("last_count", count, 2);
    chk("last_can", can_alloc, 1);
    next_step();
    for (int i = 0; i < 2; i++) begin
      req0 = 1; req1 = 1; #1;
      chk("empty_count", count, 0);
      chk("empty_can", can_alloc, 0);
      chk("empty_resp0", resp0, 32);
      next_step();
    end
    c0v = 1; c0w = 1; c0o = 5; c1v = 1; c1w = 1; c1o = 7; #1;
    chk("refill_pre_count", count, 0);
    next_step();
    req0 = 1; #1;
    chk("refill_resp0", resp0, 5);
    chk("refill_resp1", resp1, 7);
    chk("refill_count", count, 2);
    chk("refill_can", can_alloc, 1);
    // Asynchronous reset in the middle of a cycle
    #2 reset_n = 0; #1;
    chk("async_rst_count", count, 32);
    chk("async_rst_resp0", resp0, 32);
    chk("async_rst_can", can_alloc, 1);
    next_step();
    reset_n = 1;

    // Flush rolls head back to the commit pointer
    do_reset();
    req0 = 1; req1 = 1; #1; next_step();
    req0 = 1; req1 = 1; #1; next_step();
    c0v = 1; c0w = 1; c0o = 3; #1;
    chk("flush_pre_count", count, 28);
    next_step();
    flush = 1; req0 = 1; #1;
    chk("flush_cycle_count", count, 29);
    next_step(); #1;
    chk("flush_resp0", resp0, 33);
    chk("flush_count", count, 32);
    next_step();

    // Commit of old_prd=0 advances arch_head without pushing
    do_reset();
    req0 = 1; c0v = 1; c0w = 1; c0o = 0; #1;
    chk("p0_resp0", resp0, 32);
    next_step(); #1;
    chk("p0_count", count, 31);
    chk("p0_resp0_next", resp0, 33);
    next_step();
    flush = 1; #1; next_step(); #1;
    chk("p0_flush_count", count, 31);
    chk("p0_flush_resp0", resp0, 33);
    next_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
